// File: rtl/lcd_access_arbiter_pkg.sv
// Shared definitions for the LCD access arbiter: controller state encoding
// and LCD timing constants. The control block uses the same state names.
// No logic here; types and constants only.
package lcd_access_arbiter_pkg;

  // Arbiter/controller sequencing states.
  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_IDLE  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } lcd_state_t;

  // 15 ms LCD power-up wait at the 2614 Hz core clock.
  localparam int LCD_POWERUP_WAIT = 40;
  // Longest a single window job may keep the control block running.
  localparam int LCD_TIMEOUT      = 255;
  localparam int LCD_WIDTH_MEM    = 4;
  localparam int LCD_N_REQ        = 2;

endpackage

// File: rtl/lcd_access_arbiter_if.sv
// Requester/control-block bus of the LCD access arbiter.
// master: requesters + control block (drive req, windows, overflow).
// slave : the arbiter (drives grant, done, error, busy, latched window, ctrl reset).
interface lcd_access_arbiter_if #(
  parameter int N_REQ     = 2,
  parameter int WIDTH_MEM = 4
);
  logic [N_REQ-1:0]           req;             // level request per requester
  logic [N_REQ*WIDTH_MEM-1:0] addr_begin;      // packed window starts
  logic [N_REQ*WIDTH_MEM-1:0] addr_end;        // packed window ends (inclusive)
  logic                       overflow;        // control block: window finished
  logic [N_REQ-1:0]           grant;           // one-hot owner
  logic [N_REQ-1:0]           done;            // completion pulse to owner
  logic                       error;           // pulses with done on failure
  logic                       busy;            // arbiter not idle
  logic [WIDTH_MEM-1:0]       lcd_addr_begin;  // latched window start
  logic [WIDTH_MEM-1:0]       lcd_addr_end;    // latched window end
  logic                       ctrl_rst_n;      // control block reset, active-low

  modport master (
    output req, addr_begin, addr_end, overflow,
    input  grant, done, error, busy, lcd_addr_begin, lcd_addr_end, ctrl_rst_n
  );

  modport slave (
    input  req, addr_begin, addr_end, overflow,
    output grant, done, error, busy, lcd_addr_begin, lcd_addr_end, ctrl_rst_n
  );
endinterface

// File: rtl/lcd_access_arbiter_rr_arbiter.sv
// Round-robin pick: first set request searching last+1, last+2, ... mod N_REQ.
// Latency: purely combinational.
// Backpressure: none; o_valid low when no request is set.
// Ports: i_req (requests), i_last (previous owner index), o_grant (one-hot), o_valid.
module lcd_access_arbiter_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int LW    = 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [LW-1:0]    i_last,
  output logic [N_REQ-1:0] o_grant,
  output logic             o_valid
);

  // Outer loop walks priority order; inner loop matches the rotated index
  // against a constant position so every bit select stays static.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    for (int j = 1; j <= N_REQ; j++) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!o_valid && i_req[k] && (((int'(i_last) + j) % N_REQ) == k)) begin
          o_grant[k] = 1'b1;
          o_valid    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_access_arbiter.sv
// Shares the LCD command-memory/control path among N_REQ requesters round-robin.
// Latency: grant 1 cycle after request in IDLE; done 3 cycles + RUN length later.
// Backpressure: level requests wait in IDLE; a job ends on overflow edge or watchdog.
// Ports: i_clk, i_rst_n (async active-low), bus (slave modport: requests, windows,
//        overflow in; grant, done, error, busy, latched window, ctrl_rst_n out).
module lcd_access_arbiter
  import lcd_access_arbiter_pkg::*;
#(
  parameter int WIDTH_MEM    = LCD_WIDTH_MEM,
  parameter int N_REQ        = LCD_N_REQ,
  parameter int POWERUP_WAIT = LCD_POWERUP_WAIT,
  parameter int TIMEOUT      = LCD_TIMEOUT
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  lcd_access_arbiter_if.slave  bus
);

  localparam int LW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int PUW = $clog2(POWERUP_WAIT + 1);

  localparam logic [LW-1:0]  LAST_RST = LW'(N_REQ - 1);
  localparam logic [WDW-1:0] WD_MAX   = WDW'(TIMEOUT);
  localparam logic [PUW-1:0] PU_LAST  = PUW'(POWERUP_WAIT - 1);

  lcd_state_t           state;
  logic [PUW-1:0]       pu_cnt;
  logic [WDW-1:0]       wd_cnt;
  logic [LW-1:0]        last;
  logic                 ovf_prev;
  logic                 err_flag;
  logic [N_REQ-1:0]     grant_q;
  logic [N_REQ-1:0]     done_q;
  logic                 error_q;
  logic                 busy_q;
  logic [WIDTH_MEM-1:0] begin_q;
  logic [WIDTH_MEM-1:0] end_q;
  logic                 ctrl_q;

  logic [N_REQ-1:0]     arb_grant;
  logic                 arb_valid;
  logic [WIDTH_MEM-1:0] win_begin;
  logic [WIDTH_MEM-1:0] win_end;
  logic [LW-1:0]        owner_idx;
  logic [WDW-1:0]       wd_inc;

  lcd_access_arbiter_rr_arbiter #(
    .N_REQ (N_REQ),
    .LW    (LW)
  ) u_rr (
    .i_req   (bus.req),
    .i_last  (last),
    .o_grant (arb_grant),
    .o_valid (arb_valid)
  );

  // Winner's window, selected by the one-hot arbiter result.
  always_comb begin
    win_begin = '0;
    win_end   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (arb_grant[k]) begin
        win_begin = bus.addr_begin[k*WIDTH_MEM +: WIDTH_MEM];
        win_end   = bus.addr_end[k*WIDTH_MEM +: WIDTH_MEM];
      end
    end
  end

  // Owner index of the current job, becomes the new round-robin anchor.
  always_comb begin
    owner_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_q[k]) owner_idx = LW'(k);
    end
  end

  assign wd_inc = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_PWRUP;
      pu_cnt   <= '0;
      wd_cnt   <= '0;
      last     <= LAST_RST;
      ovf_prev <= 1'b0;
      err_flag <= 1'b0;
      grant_q  <= '0;
      done_q   <= '0;
      error_q  <= 1'b0;
      busy_q   <= 1'b1;
      begin_q  <= '0;
      end_q    <= '0;
      ctrl_q   <= 1'b0;
    end else begin
      done_q  <= '0;
      error_q <= 1'b0;
      case (state)
        ST_PWRUP: begin
          if (pu_cnt == PU_LAST) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            pu_cnt <= pu_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          ctrl_q <= 1'b0;
          if (arb_valid) begin
            grant_q <= arb_grant;
            begin_q <= win_begin;
            end_q   <= win_end;
            busy_q  <= 1'b1;
            // An inverted window is never handed to the control block.
            if (win_begin > win_end) begin
              err_flag <= 1'b1;
              state    <= ST_DONE;
            end else begin
              err_flag <= 1'b0;
              state    <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          wd_cnt   <= '0;
          ovf_prev <= 1'b0;
          ctrl_q   <= 1'b1;
          state    <= ST_RUN;
        end
        ST_RUN: begin
          ovf_prev <= bus.overflow;
          wd_cnt   <= wd_inc;
          // Overflow is checked first so it wins a tie with the watchdog.
          if (bus.overflow && !ovf_prev) begin
            ctrl_q   <= 1'b0;
            err_flag <= 1'b0;
            state    <= ST_DONE;
          end else if (wd_inc == WD_MAX) begin
            ctrl_q   <= 1'b0;
            err_flag <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= grant_q;
          error_q <= err_flag;
          grant_q <= '0;
          last    <= owner_idx;
          ctrl_q  <= 1'b0;
          busy_q  <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          grant_q <= '0;
          ctrl_q  <= 1'b0;
          busy_q  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.grant          = grant_q;
  assign bus.done           = done_q;
  assign bus.error          = error_q;
  assign bus.busy           = busy_q;
  assign bus.lcd_addr_begin = begin_q;
  assign bus.lcd_addr_end   = end_q;
  assign bus.ctrl_rst_n     = ctrl_q;

endmodule
